// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice array and its issue stage:
// R-type funct codes and the slice op-select encodings.
package alu_pkg;

  // MIPS R-type funct codes handled by the slice array
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Slice op-select bus; bit 2 doubles as the B-invert / carry-in control
  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SUB = 3'b110;
  localparam logic [2:0] SIG_SLT = 3'b111;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct-code decoder: funct -> slice op-select, carry-in, illegal flag.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] signal,
  output logic       cin,
  output logic       illegal
);

  // Table lookup; unknown codes fall back to AND and are flagged
  always_comb begin
    signal  = SIG_AND;
    illegal = 1'b0;
    case (funct)
      FN_AND:  signal = SIG_AND;
      FN_OR:   signal = SIG_OR;
      FN_ADD:  signal = SIG_ADD;
      FN_SUB:  signal = SIG_SUB;
      FN_SLT:  signal = SIG_SLT;
      default: begin
        signal  = SIG_AND;
        illegal = 1'b1;
      end
    endcase
    // Subtract-type ops invert B and need the +1 on slice 0
    cin = signal[2];
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the ALU slice array. Decodes the funct
// code and holds the result in an output register backed by a skid register,
// so in_ready depends only on registered state (never on out_ready).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_signal,
  output logic             out_cin,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       signal;
    logic             cin;
    logic             illegal;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       dec_signal;
  logic             dec_cin;
  logic             dec_illegal;
  slot_t            in_slot;
  slot_t            or_reg;
  slot_t            sk_reg;
  logic             or_valid_reg;
  logic             sk_valid_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic             accept;
  logic             consume;

  alu_funct_decode u_decode (
    .funct   (in_funct),
    .signal  (dec_signal),
    .cin     (dec_cin),
    .illegal (dec_illegal)
  );

  assign in_slot = '{a: in_a, b: in_b, signal: dec_signal, cin: dec_cin, illegal: dec_illegal};

  // Ready only when the skid slot is free; a full skid slot is the only back-pressure
  assign in_ready = ~sk_valid_reg & ~reset;
  assign accept   = in_valid & in_ready;
  assign consume  = or_valid_reg & out_ready;

  // Output/skid register pair: refill OR from SK first, otherwise from the input
  always_ff @(posedge clk) begin
    if (reset) begin
      or_reg       <= '0;
      sk_reg       <= '0;
      or_valid_reg <= 1'b0;
      sk_valid_reg <= 1'b0;
    end else if (consume) begin
      if (sk_valid_reg) begin
        // in_ready is low here, so no accept can collide with the SK move
        or_reg       <= sk_reg;
        sk_valid_reg <= 1'b0;
      end else if (accept) begin
        or_reg <= in_slot;
      end else begin
        or_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_reg) begin
        or_reg       <= in_slot;
        or_valid_reg <= 1'b1;
      end else begin
        sk_reg       <= in_slot;
        sk_valid_reg <= 1'b1;
      end
    end
  end

  // Saturating count of accepted illegal funct codes
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_reg <= '0;
    end else if (accept && dec_illegal && (err_count_reg != CNT_MAX)) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign out_valid   = or_valid_reg;
  assign out_a       = or_reg.a;
  assign out_b       = or_reg.b;
  assign out_signal  = or_reg.signal;
  assign out_cin     = or_reg.cin;
  assign out_illegal = or_reg.illegal;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of the ALU issue stage: decode table,
// 1-cycle latency, skid buffering under stall, error counter saturation,
// mid-stream reset and ordering under random valid/ready traffic.
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int BUS_W = 2 * WIDTH + 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [2:0]       out_signal;
  logic             out_cin;
  logic             out_illegal;
  logic [CNT_W-1:0] err_count;

  int vectors;
  int miscompares;

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_signal  (out_signal),
    .out_cin     (out_cin),
    .out_illegal (out_illegal),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    in_valid = v;
    in_funct = f;
    in_a     = a;
    in_b     = b;
  endtask

  // Reference decode: {signal, cin, illegal}
  function automatic logic [4:0] ref_dec(input logic [5:0] f);
    case (f)
      6'h24:   return 5'b000_0_0;
      6'h25:   return 5'b001_0_0;
      6'h20:   return 5'b010_0_0;
      6'h22:   return 5'b110_1_0;
      6'h2A:   return 5'b111_1_0;
      default: return 5'b000_0_1;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] cur_bus();
    return {out_a, out_b, out_signal, out_cin, out_illegal};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 6'h00, '0, '0);
    out_ready = 1'b0;
    repeat (3) step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b err_count=%0d, required 0 0 0",
               out_valid, in_ready, err_count);
    end
    vectors++;
    if (cur_bus() !== '0) begin
      miscompares++;
      $display("FAIL reset_data: bus=%h, required 0", cur_bus());
    end
    reset = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, 6'h20, 32'd5, 32'd3);
    step();
    drive(1'b0, 6'h00, '0, '0);
    vectors++;
    if (out_valid !== 1'b1 || out_signal !== 3'b010 || out_cin !== 1'b0 || out_illegal !== 1'b0 ||
        out_a !== 32'd5 || out_b !== 32'd3) begin
      miscompares++;
      $display("FAIL add: valid=%b sig=%b cin=%b ill=%b a=%h b=%h, required 1 010 0 0 5 3",
               out_valid, out_signal, out_cin, out_illegal, out_a, out_b);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_drain: out_valid=%b, required 0", out_valid);
    end
    $display("test_add done");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 6'h22, 32'd7, 32'd9);
    step();
    drive(1'b1, 6'h2A, 32'h8000_0000, 32'd1);
    vectors++;
    if (out_valid !== 1'b1 || out_signal !== 3'b110 || out_cin !== 1'b1 ||
        out_a !== 32'd7 || out_b !== 32'd9) begin
      miscompares++;
      $display("FAIL b2b_sub: valid=%b sig=%b cin=%b a=%h b=%h, required 1 110 1 7 9",
               out_valid, out_signal, out_cin, out_a, out_b);
    end
    step();
    drive(1'b0, 6'h00, '0, '0);
    vectors++;
    if (out_valid !== 1'b1 || out_signal !== 3'b111 || out_cin !== 1'b1 ||
        out_a !== 32'h8000_0000 || out_b !== 32'd1) begin
      miscompares++;
      $display("FAIL b2b_slt: valid=%b sig=%b cin=%b a=%h b=%h, required 1 111 1 80000000 1",
               out_valid, out_signal, out_cin, out_a, out_b);
    end
    step();
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    logic [BUS_W-1:0] op1_bus;
    out_ready = 1'b0;
    drive(1'b1, 6'h24, 32'h1, 32'h10);
    step();
    op1_bus = {32'h1, 32'h10, 3'b000, 1'b0, 1'b0};
    drive(1'b1, 6'h25, 32'h2, 32'h20);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || cur_bus() !== op1_bus) begin
      miscompares++;
      $display("FAIL stall_op1: in_ready=%b valid=%b bus=%h, required 1 1 %h",
               in_ready, out_valid, cur_bus(), op1_bus);
    end
    step();
    drive(1'b1, 6'h20, 32'h3, 32'h30);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur_bus() !== op1_bus) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b bus=%h, required 0 1 %h",
                 i, in_ready, out_valid, cur_bus(), op1_bus);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_a !== 32'h2 || out_signal !== 3'b001 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_op2: valid=%b a=%h sig=%b in_ready=%b, required 1 2 001 1",
               out_valid, out_a, out_signal, in_ready);
    end
    step();
    drive(1'b0, 6'h00, '0, '0);
    vectors++;
    if (out_valid !== 1'b1 || out_a !== 32'h3 || out_b !== 32'h30 || out_signal !== 3'b010) begin
      miscompares++;
      $display("FAIL stall_op3: valid=%b a=%h b=%h sig=%b, required 1 3 30 010",
               out_valid, out_a, out_b, out_signal);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain: out_valid=%b, required 0", out_valid);
    end
    $display("test_stall done");
  endtask

  task automatic test_illegal();
    int exp_cnt;
    out_ready = 1'b1;
    drive(1'b1, 6'h3F, 32'hAAAA_5555, 32'h1234_5678);
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_cnt = (i > 255) ? 255 : i;
      vectors++;
      if (err_count !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL err_count[%0d]: got %0d, required %0d", i, err_count, exp_cnt);
      end
      if (i == 1 || i == 300) begin
        vectors++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_signal !== 3'b000 ||
            out_cin !== 1'b0) begin
          miscompares++;
          $display("FAIL illegal_decode[%0d]: valid=%b ill=%b sig=%b cin=%b, required 1 1 000 0",
                   i, out_valid, out_illegal, out_signal, out_cin);
        end
      end
    end
    drive(1'b0, 6'h00, '0, '0);
    step();
    $display("test_illegal done, err_count=%0d", err_count);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 6'h24, 32'hA, 32'hA);
    step();
    drive(1'b1, 6'h3F, 32'hB, 32'hB);
    step();
    drive(1'b0, 6'h00, '0, '0);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_full: in_ready=%b valid=%b, required 0 1", in_ready, out_valid);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || err_count !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b err_count=%0d in_ready=%b, required 0 0 0",
               out_valid, err_count, in_ready);
    end
    reset = 1'b0;
    drive(1'b1, 6'h20, 32'h11, 32'h22);
    step();
    drive(1'b0, 6'h00, '0, '0);
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_a !== 32'h11 || out_b !== 32'h22 || out_signal !== 3'b010) begin
      miscompares++;
      $display("FAIL mid_first: valid=%b a=%h b=%h sig=%b, required 1 11 22 010",
               out_valid, out_a, out_b, out_signal);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_alone: out_valid=%b, required 0 (stale op emitted)", out_valid);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [BUS_W-1:0] q[$];
    logic [BUS_W-1:0] prev_bus;
    logic [BUS_W-1:0] exp_bus;
    logic [5:0]       fn_tab[7];
    logic             prev_hold;
    logic             acc;
    logic             con;
    int sent;
    int got;
    int cycles;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00};
    sent = 0;
    got = 0;
    cycles = 0;
    prev_hold = 1'b0;
    prev_bus = '0;
    while ((sent < 10000 || q.size() != 0) && cycles < 60000) begin
      cycles++;
      if (prev_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || cur_bus() !== prev_bus) begin
          miscompares++;
          $display("FAIL hold_rule cycle %0d: valid=%b bus=%h, required 1 %h",
                   cycles, out_valid, cur_bus(), prev_bus);
        end
      end
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      in_funct  = fn_tab[$urandom_range(0, 6)];
      in_a      = ($urandom_range(0, 15) == 0) ? '1 : WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra cycle %0d: bus=%h, required no output", cycles, cur_bus());
        end else begin
          exp_bus = q.pop_front();
          got++;
          if (cur_bus() !== exp_bus) begin
            miscompares++;
            $display("FAIL rand_order op %0d: bus=%h, required %h", got, cur_bus(), exp_bus);
          end
        end
      end
      if (acc) begin
        q.push_back({in_a, in_b, ref_dec(in_funct)});
        sent++;
      end
      prev_hold = out_valid && !out_ready;
      prev_bus  = cur_bus();
      step();
    end
    drive(1'b0, 6'h00, '0, '0);
    out_ready = 1'b1;
    vectors++;
    if (got != 10000 || q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_count: consumed %0d left %0d after %0d cycles, required 10000 0",
               got, q.size(), cycles);
    end
    $display("test_random done: %0d ops in %0d cycles", got, cycles);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 6'h00, '0, '0);
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
